// File: rtl/nn_calc_sequencer.sv
// Neural-network layer sequencer: streams pixels and weights from RAM,
// multiply-accumulates one neuron at a time, and stores saturated results.
module nn_calc_sequencer #(
    parameter int N_PIX = 784,
    parameter int N_OUT = 10,
    parameter int SHIFT = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start_calc,
    output logic        pixel_rd_en,
    output logic [9:0]  pixel_rd_addr,
    input  logic [15:0] pixel_rd_data,
    output logic        weight_rd_en,
    output logic [12:0] weight_rd_addr,
    input  logic [15:0] weight_rd_data,
    input  logic [3:0]  result_addr,
    output logic [16:0] result_output,
    output logic        busy,
    output logic        done_calc
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RUN   = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] STORE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [9:0]  LAST_P   = 10'(N_PIX - 1);
    localparam logic [3:0]  LAST_N   = 4'(N_OUT - 1);
    localparam logic [4:0]  N_OUT_W  = 5'(N_OUT);
    localparam logic [12:0] N_PIX_W  = 13'(N_PIX);

    logic [2:0]         state;
    logic [3:0]         n;
    logic [9:0]         p;
    logic signed [41:0] acc;
    logic               vld;
    logic               start_q;
    logic               start_armed;
    logic signed [16:0] result [16];

    logic               start_edge;
    logic signed [32:0] w_ext;
    logic signed [32:0] p_ext;
    logic signed [32:0] prod;
    logic signed [41:0] acc_next;
    logic signed [41:0] shifted;
    logic signed [16:0] sat;

    // Start is a rising edge; start_armed blocks a level held high through reset release.
    always_comb begin
        start_edge = start_calc & ~start_q & start_armed;
    end

    // Multiply-accumulate datapath and 17-bit saturation of the shifted accumulator.
    always_comb begin
        w_ext    = {{17{weight_rd_data[15]}}, weight_rd_data};
        p_ext    = {17'd0, pixel_rd_data};
        prod     = w_ext * p_ext;
        acc_next = acc + {{9{prod[32]}}, prod};
        shifted  = acc >>> SHIFT;
        if (shifted > 42'sd65535)
            sat = 17'h0FFFF;
        else if (shifted < -42'sd65536)
            sat = 17'h10000;
        else
            sat = shifted[16:0];
    end

    // Status, read strobes and addresses decoded from the current state.
    always_comb begin
        busy           = (state == RUN) || (state == DRAIN) || (state == STORE);
        done_calc      = (state == DONE);
        pixel_rd_en    = (state == RUN);
        weight_rd_en   = (state == RUN);
        pixel_rd_addr  = '0;
        weight_rd_addr = '0;
        if (state == RUN) begin
            pixel_rd_addr  = p;
            weight_rd_addr = 13'(n) * N_PIX_W + 13'(p);
        end
    end

    // Combinational result read; out-of-range selects return zero.
    always_comb begin
        if ({1'b0, result_addr} < N_OUT_W)
            result_output = result[result_addr];
        else
            result_output = '0;
    end

    // Sequencer FSM, accumulator, valid pipe and result registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            n           <= '0;
            p           <= '0;
            acc         <= '0;
            vld         <= 1'b0;
            start_q     <= 1'b0;
            start_armed <= 1'b0;
            for (int unsigned i = 0; i < 16; i++)
                result[i] <= '0;
        end else begin
            start_q     <= start_calc;
            start_armed <= start_armed | ~start_calc;
            vld         <= (state == RUN);
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        n     <= '0;
                        p     <= '0;
                        acc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (vld)
                        acc <= acc_next;
                    if (p == LAST_P) begin
                        p     <= '0;
                        state <= DRAIN;
                    end else begin
                        p <= p + 10'd1;
                    end
                end
                DRAIN: begin
                    if (vld)
                        acc <= acc_next;
                    state <= STORE;
                end
                STORE: begin
                    result[n] <= sat;
                    acc       <= '0;
                    n         <= n + 4'd1;
                    state     <= (n < LAST_N) ? RUN : DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_calc_sequencer.sv
// Scoreboard bench for nn_calc_sequencer (N_PIX=4, N_OUT=2; SHIFT=0 and SHIFT=8 instances).
module tb_nn_calc_sequencer;

    typedef struct {
        int    addr;
        int    value;
        string name;
    } res_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic        p_en0, w_en0, busy0, done0;
    logic [9:0]  p_addr0;
    logic [12:0] w_addr0;
    logic [15:0] p_data0 = '0, w_data0 = '0;
    logic [3:0]  ra0 = '0;
    logic [16:0] res_out0;

    logic        p_en1, w_en1, busy1, done1;
    logic [9:0]  p_addr1;
    logic [12:0] w_addr1;
    logic [15:0] p_data1 = '0, w_data1 = '0;
    logic [3:0]  ra1 = '0;
    logic [16:0] res_out1;

    logic [15:0] pix_mem [4];
    logic [15:0] wgt_mem [8];

    int n_checks = 0;
    int n_fails  = 0;

    res_t res_q0[$];
    res_t res_q1[$];
    int   addr_q0[$];
    event sb_ev0;

    always #5 clk = ~clk;

    nn_calc_sequencer #(.N_PIX(4), .N_OUT(2), .SHIFT(0)) dut (
        .clk(clk), .n_rst(n_rst), .start_calc(start0),
        .pixel_rd_en(p_en0), .pixel_rd_addr(p_addr0), .pixel_rd_data(p_data0),
        .weight_rd_en(w_en0), .weight_rd_addr(w_addr0), .weight_rd_data(w_data0),
        .result_addr(ra0), .result_output(res_out0), .busy(busy0), .done_calc(done0)
    );

    nn_calc_sequencer #(.N_PIX(4), .N_OUT(2), .SHIFT(8)) dut_s8 (
        .clk(clk), .n_rst(n_rst), .start_calc(start1),
        .pixel_rd_en(p_en1), .pixel_rd_addr(p_addr1), .pixel_rd_data(p_data1),
        .weight_rd_en(w_en1), .weight_rd_addr(w_addr1), .weight_rd_data(w_data1),
        .result_addr(ra1), .result_output(res_out1), .busy(busy1), .done_calc(done1)
    );

    // Synchronous-read RAM models: data valid one cycle after the strobe.
    always @(posedge clk) begin
        if (p_en0) p_data0 <= pix_mem[p_addr0[1:0]];
        if (w_en0) w_data0 <= wgt_mem[w_addr0[2:0]];
        if (p_en1) p_data1 <= pix_mem[p_addr1[1:0]];
        if (w_en1) w_data1 <= wgt_mem[w_addr1[2:0]];
    end

    function automatic void check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endfunction

    // Result monitor for the SHIFT=0 instance: drains expectations on done or on request.
    initial begin
        res_t e;
        forever begin
            @(posedge done0 or sb_ev0);
            #1;
            while (res_q0.size() > 0) begin
                e = res_q0.pop_front();
                ra0 = 4'(e.addr);
                #1;
                check(e.name, longint'($signed(res_out0)), longint'(e.value));
            end
        end
    end

    // Result monitor for the SHIFT=8 instance.
    initial begin
        res_t e;
        forever begin
            @(posedge done1);
            #1;
            while (res_q1.size() > 0) begin
                e = res_q1.pop_front();
                ra1 = 4'(e.addr);
                #1;
                check(e.name, longint'($signed(res_out1)), longint'(e.value));
            end
        end
    end

    // Address monitor: each strobe must match the next expected weight address.
    initial begin
        int exp_w;
        forever begin
            @(negedge clk);
            if (w_en0) begin
                check("pixel_en_eq_weight_en", longint'(p_en0), 1);
                n_checks++;
                if (addr_q0.size() == 0) begin
                    n_fails++;
                    $display("FAIL unexpected_strobe: got weight addr %0d, required no strobe", w_addr0);
                end else begin
                    exp_w = addr_q0.pop_front();
                    check("weight_rd_addr", longint'(w_addr0), longint'(exp_w));
                    check("pixel_rd_addr", longint'(p_addr0), longint'(exp_w % 4));
                end
            end else begin
                check("pixel_en_idle", longint'(p_en0), 0);
                check("pixel_addr_idle", longint'(p_addr0), 0);
                check("weight_addr_idle", longint'(w_addr0), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load(input int px [4], input int wt [8]);
        for (int i = 0; i < 4; i++) pix_mem[i] = 16'(px[i]);
        for (int i = 0; i < 8; i++) wgt_mem[i] = 16'(wt[i]);
    endtask

    task automatic expect_run0(input int r0, input int r1, input string tag);
        for (int i = 0; i < 8; i++) addr_q0.push_back(i);
        res_q0.push_back('{0, r0, {tag, "_res0"}});
        res_q0.push_back('{1, r1, {tag, "_res1"}});
    endtask

    // Issues a start edge and counts cycles from the first busy cycle to done.
    task automatic start_and_time0(input bit toggle, output int lat);
        @(negedge clk);
        start0 = 1'b1;
        lat = 0;
        for (int i = 0; i < 5 && !busy0; i++) @(negedge clk);
        start0 = 1'b0;
        if (!busy0) begin
            n_checks++; n_fails++;
            $display("FAIL busy_rise: got busy 0, required 1 within 5 cycles");
            lat = -1;
            return;
        end
        check("done_low_in_run", longint'(done0), 0);
        while (!done0 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (toggle && lat == 2) start0 = 1'b1;
            if (toggle && lat == 4) start0 = 1'b0;
        end
        check("done_high", longint'(done0), 1);
        check("busy_in_done", longint'(busy0), 0);
    endtask

    initial begin
        int lat;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy0), 0);
        check("rst_done", longint'(done0), 0);
        check("rst_w_en", longint'(w_en0), 0);
        res_q0.push_back('{0, 0, "rst_res0"});
        res_q0.push_back('{1, 0, "rst_res1"});
        -> sb_ev0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Scenario 1 + address sequence + out-of-range select
        load('{1, 2, 3, 4}, '{1, 1, 1, 1, -1, 0, 0, 2});
        expect_run0(10, 7, "s1");
        res_q0.push_back('{5, 0, "s6_addr5"});
        start_and_time0(1'b0, lat);
        check("s1_latency", longint'(lat), 12);
        repeat (3) @(negedge clk);

        // Scenario 2: saturation both ways
        load('{65535, 65535, 65535, 65535}, '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767});
        expect_run0(65535, 65535, "s2_pos");
        start_and_time0(1'b0, lat);
        repeat (3) @(negedge clk);
        load('{65535, 65535, 65535, 65535}, '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768});
        expect_run0(-65536, -65536, "s2_neg");
        start_and_time0(1'b0, lat);
        repeat (3) @(negedge clk);

        // Scenario 3: arithmetic shift on the SHIFT=8 instance
        load('{256, 0, 0, 0}, '{-3, 0, 0, 0, 0, 0, 0, 0});
        res_q1.push_back('{0, -3, "s3_res0"});
        res_q1.push_back('{1, 0, "s3_res1"});
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("s3_done", longint'(done1), 1);
        repeat (3) @(negedge clk);

        // Scenario 4: start toggled during RUN, then rerun from DONE
        load('{1, 2, 3, 4}, '{1, 1, 1, 1, -1, 0, 0, 2});
        expect_run0(10, 7, "s4");
        start_and_time0(1'b1, lat);
        check("s4_latency", longint'(lat), 12);
        repeat (2) @(negedge clk);
        load('{4, 3, 2, 1}, '{1, 0, 0, 0, 0, 0, 0, 3});
        expect_run0(4, 3, "s4_rerun");
        start_and_time0(1'b0, lat);
        check("s4_rerun_latency", longint'(lat), 12);
        repeat (3) @(negedge clk);

        // Scenario 5: reset during neuron 1, start held through release
        load('{1, 2, 3, 4}, '{1, 1, 1, 1, -1, 0, 0, 2});
        for (int i = 0; i < 8; i++) addr_q0.push_back(i);
        @(negedge clk);
        start0 = 1'b1;
        for (int i = 0; i < 5 && !busy0; i++) @(negedge clk);
        check("s5_busy", longint'(busy0), 1);
        repeat (8) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("s5_rst_busy", longint'(busy0), 0);
        check("s5_rst_done", longint'(done0), 0);
        check("s5_rst_p_en", longint'(p_en0), 0);
        check("s5_rst_w_addr", longint'(w_addr0), 0);
        addr_q0.delete();
        res_q0.push_back('{0, 0, "s5_rst_res0"});
        res_q0.push_back('{1, 0, "s5_rst_res1"});
        -> sb_ev0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("s5_no_start_busy", longint'(busy0), 0);
        end
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        expect_run0(10, 7, "s5_recover");
        start_and_time0(1'b0, lat);
        check("s5_latency", longint'(lat), 12);
        repeat (3) @(negedge clk);

        check("addr_queue_drained", longint'(addr_q0.size()), 0);
        check("res_queue0_drained", longint'(res_q0.size()), 0);
        check("res_queue1_drained", longint'(res_q1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/nn_calc_sequencer.md
NN_CALC_SEQUENCER -- requirements
Module: nn_calc_sequencer

Interface
REQ-001 Parameter N_PIX, default 784; pixels per image and weights per neuron.
REQ-002 Parameter N_OUT, default 10; number of output neurons (<=16).
REQ-003 Parameter SHIFT, default 8; arithmetic right shift applied to the accumulator before saturation.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 n_rst  in  1  reset, asynchronous, active-low.
REQ-006 start_calc  in  1  level from the control CSR; its rising edge requests a calculation.
REQ-007 pixel_rd_en  out  1  pixel RAM read strobe.
REQ-008 pixel_rd_addr  out  10  pixel RAM read address = pixel index p.
REQ-009 pixel_rd_data  in  16  unsigned pixel; valid exactly one cycle after the strobe.
REQ-010 weight_rd_en  out  1  weight RAM read strobe; always equal to pixel_rd_en.
REQ-011 weight_rd_addr  out  13  weight RAM read address = n*N_PIX + p.
REQ-012 weight_rd_data  in  16  signed weight; valid one cycle after the strobe.
REQ-013 result_addr  in  4  result register select.
REQ-014 result_output  out  17  signed result for result_addr; combinational read.
REQ-015 busy  out  1  high while a calculation runs.
REQ-016 done_calc  out  1  high after a completed calculation.

Function
REQ-017 The block SHALL use the states IDLE, RUN, DRAIN, STORE and DONE.
REQ-018 Start SHALL be a rising edge of start_calc: registered start_calc was 0 and is now 1.
REQ-019 On start in IDLE or DONE: n=0, p=0, accumulator=0, done_calc=0, next state RUN.
REQ-020 A start edge in RUN, DRAIN or STORE SHALL be ignored.
REQ-021 RUN: each cycle, assert both read strobes with address p (pixel) and n*N_PIX+p (weight), then p++.
REQ-022 RUN SHALL go to DRAIN in the cycle after the address with p=N_PIX-1 is issued; p is then cleared.
REQ-023 A one-cycle valid pipe SHALL follow the strobes; when valid, acc += signed(weight) * {1'b0,pixel}.
REQ-024 The accumulator SHALL be 42-bit signed; the product is 33-bit signed and sign-extended before the add.
REQ-025 DRAIN SHALL last 1 cycle, performs the final accumulate, and issues no read.
REQ-026 STORE SHALL last 1 cycle and write result[n] = sat17(acc >>> SHIFT).
REQ-027 sat17 SHALL clamp to the range -65536..65535.
REQ-028 In the same STORE cycle the block SHALL clear the accumulator and increment n.
REQ-029 After STORE, the next state SHALL be RUN if n < N_OUT-1, otherwise DONE.
REQ-030 Each neuron SHALL take exactly N_PIX+2 cycles; a full calculation SHALL take N_OUT*(N_PIX+2) cycles from the first RUN cycle to DONE entry.
REQ-031 busy SHALL be 1 in RUN, DRAIN and STORE, and 0 otherwise.
REQ-032 done_calc SHALL be 1 only in DONE; DONE holds until the next start edge.
REQ-033 result_output SHALL be result[result_addr] when result_addr < N_OUT, otherwise 0.
REQ-034 Results SHALL be readable at any time, including while busy; stale entries are returned until overwritten.
REQ-035 Read strobes SHALL be 0 outside RUN; addresses SHALL be 0 when strobes are 0.

Reset
REQ-036 While n_rst=0: state IDLE; n, p, accumulator, valid pipe and registered start_calc cleared.
REQ-037 While n_rst=0: all result registers = 0, busy=0, done_calc=0, read strobes and addresses 0.
REQ-038 Reset asserted mid-calculation SHALL abort immediately and apply REQ-036/037.
REQ-039 If start_calc is held 1 through reset release, no start SHALL occur until it goes 0 then 1.

Verification (N_PIX=4, N_OUT=2, SHIFT=0 unless noted)
REQ-040 Scenario 1: pixels {1,2,3,4}, weights n0 {1,1,1,1}, n1 {-1,0,0,2}; pulse start. Required: result[0]=10, result[1]=7; done_calc rises 12 cycles after the first RUN cycle; busy=0 in DONE.
REQ-041 Scenario 2: pixels all 65535, weights all 32767. Required: result[0]=65535 (positive saturation). With weights all -32768: result[0]=-65536.
REQ-042 Scenario 3: SHIFT=8, pixel {256,0,0,0}, weight {-3,0,0,0}. Required: result[0]=-3 (arithmetic shift).
REQ-043 Scenario 4: toggle start_calc during RUN. Required: the calculation is unaffected with identical cycle count; a start after DONE reruns and clears done_calc next cycle.
REQ-044 Scenario 5: assert n_rst during neuron 1 of RUN. Required: all outputs 0 and result[0]=0 after reset; start held high across release triggers nothing.
REQ-045 Scenario 6: check address sequence. Required: weight_rd_addr = 0..3 then 4..7 on consecutive RUN cycles; result_addr=5 reads 0.
